// File: rtl/slave_port_if.sv
// Serial bus between the bus master and slave_port: address/write bits in,
// read bits and status out, one bit per valid cycle, LSB first.
interface slave_port_if;
    logic swdata;
    logic smode;
    logic mvalid;
    logic srdata;
    logic svalid;
    logic sready;

    modport slave (
        input  swdata,
        input  smode,
        input  mvalid,
        output srdata,
        output svalid,
        output sready
    );

    modport master (
        output swdata,
        output smode,
        output mvalid,
        input  srdata,
        input  svalid,
        input  sready
    );
endinterface

// File: rtl/slave_port.sv
// Serial-to-parallel memory slave: collects an address (and write data) from the
// serial bus, issues one memory strobe, and serialises read data back.
module slave_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    slave_port_if.slave           bus,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW + 1);

    localparam logic [CW-1:0] LAST_ADDR = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] DATA_END  = CW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4,
        S_RWAIT = 3'd5,
        S_RDATA = 3'd6
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_mode;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_srdata;
    logic                  r_svalid;
    logic                  r_sready;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_mem_wen;
    logic                  r_mem_ren;

    // Address and data shift in from the top so the first (LSB) bit lands at bit 0.
    // Frame sequencer: bit collection, memory strobes and read-data serialisation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_mode      <= 1'b0;
            r_rdata     <= {DATA_WIDTH{1'b0}};
            r_srdata    <= 1'b0;
            r_svalid    <= 1'b0;
            r_sready    <= 1'b0;
            r_mem_addr  <= {ADDR_WIDTH{1'b0}};
            r_mem_wdata <= {DATA_WIDTH{1'b0}};
            r_mem_wen   <= 1'b0;
            r_mem_ren   <= 1'b0;
        end else begin
            r_mem_wen <= 1'b0;
            r_mem_ren <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.mvalid) begin
                        r_mem_addr <= {bus.swdata, r_mem_addr[ADDR_WIDTH-1:1]};
                        r_mode     <= bus.smode;
                        r_cnt      <= CW'(1);
                        r_sready   <= 1'b0;
                        r_state    <= S_ADDR;
                    end else begin
                        r_sready   <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (bus.mvalid) begin
                        r_mem_addr <= {bus.swdata, r_mem_addr[ADDR_WIDTH-1:1]};
                        if (r_cnt == LAST_ADDR) begin
                            r_cnt <= {CW{1'b0}};
                            if (r_mode) begin
                                r_state <= S_WDATA;
                            end else begin
                                r_state   <= S_READ;
                                r_mem_ren <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_WDATA: begin
                    if (bus.mvalid) begin
                        r_mem_wdata <= {bus.swdata, r_mem_wdata[DATA_WIDTH-1:1]};
                        if (r_cnt == LAST_DATA) begin
                            r_cnt     <= {CW{1'b0}};
                            r_state   <= S_WRITE;
                            r_mem_wen <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    r_sready <= 1'b1;
                    r_state  <= S_IDLE;
                end
                // Any mem_rvalid coinciding with the strobe cycle is deliberately dropped here.
                S_READ: begin
                    r_state <= S_RWAIT;
                end
                S_RWAIT: begin
                    if (mem_rvalid) begin
                        r_rdata  <= {1'b0, mem_rdata[DATA_WIDTH-1:1]};
                        r_srdata <= mem_rdata[0];
                        r_svalid <= 1'b1;
                        r_cnt    <= CW'(1);
                        r_state  <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (r_cnt == DATA_END) begin
                        r_srdata <= 1'b0;
                        r_svalid <= 1'b0;
                        r_sready <= 1'b1;
                        r_cnt    <= {CW{1'b0}};
                        r_state  <= S_IDLE;
                    end else begin
                        r_srdata <= r_rdata[0];
                        r_rdata  <= {1'b0, r_rdata[DATA_WIDTH-1:1]};
                        r_cnt    <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_srdata <= 1'b0;
                    r_svalid <= 1'b0;
                    r_sready <= 1'b0;
                    r_cnt    <= {CW{1'b0}};
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.srdata = r_srdata;
    assign bus.svalid = r_svalid;
    assign bus.sready = r_sready;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wen    = r_mem_wen;
    assign mem_ren    = r_mem_ren;

endmodule

// File: tb/tb_slave_port.sv
// Bench for slave_port: directed frame table, reset sequences and random frames
// checked against a frame-level model with its own memory image.
module tb_slave_port;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wen;
    logic          mem_ren;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;

    slave_port_if bus();

    slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            pre;
        int            stall_at;
        int            stall_len;
        int            lat;
        bit            junk;
        bit            toggle;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t          tbl [9];
    logic [DW-1:0] ph_mem    [4096];
    logic [DW-1:0] model_mem [4096];
    logic [AW-1:0] written [$];

    int n_vec = 0, n_bad = 0, cyc = 0;
    int wen_cnt, wen_cyc, ren_cnt, ren_cyc, sv_cnt, sv_first, rv_cyc, cur_lat;
    logic [AW-1:0] wen_addr, ren_addr;
    logic [DW-1:0] wen_data, sv_word;
    bit junk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wen_cnt = 0; ren_cnt = 0; sv_cnt = 0; sv_first = -1; rv_cyc = -1;
        wen_cyc = -1; ren_cyc = -1; sv_word = '0;
    endtask

    // Advance one cycle, log DUT activity, then play the memory for this cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_wen && mem_ren) begin
            n_bad++;
            $display("FAIL wen_ren_excl: both strobes high at cycle %0d", cyc);
        end
        if (!bus.svalid && bus.srdata) begin
            n_bad++;
            $display("FAIL srdata_idle: srdata=1 with svalid=0 at cycle %0d", cyc);
        end
        if (mem_wen) begin
            wen_cnt++; wen_cyc = cyc; wen_addr = mem_addr; wen_data = mem_wdata;
            ph_mem[mem_addr] = mem_wdata;
        end
        if (mem_ren) begin
            ren_cnt++; ren_cyc = cyc; ren_addr = mem_addr; rv_cyc = cyc + cur_lat;
        end
        if (bus.svalid) begin
            if (sv_cnt == 0) sv_first = cyc;
            if (sv_cnt < DW) sv_word[sv_cnt] = bus.srdata;
            sv_cnt++;
        end
        if (cyc == rv_cyc) begin
            mem_rvalid = 1'b1; mem_rdata = ph_mem[ren_addr];
        end else if (junk_en && mem_ren) begin
            mem_rvalid = 1'b1; mem_rdata = 8'hFF;
        end else begin
            mem_rvalid = 1'b0; mem_rdata = DW'($urandom);
        end
    endtask

    task automatic run_frame(input bit mode, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input int stall_at, input int stall_len, input int lat,
                             input bit junk, input bit toggle, input logic [DW-1:0] exp,
                             input string name);
        int s, nbits, nstall, exp_strobe, exp_done;
        logic rdy_before, rdy_done;
        clear_log();
        cur_lat = lat; junk_en = junk;
        check({name, " sready_start"}, 32'(bus.sready), 32'd1);
        s = cyc;
        nbits = mode ? AW + DW : AW;
        nstall = 0;
        for (int b = 0; b < nbits; b++) begin
            if (b == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    bus.mvalid = 1'b0; bus.swdata = 1'($urandom); bus.smode = 1'($urandom);
                    step();
                    nstall++;
                end
            end
            bus.mvalid = 1'b1;
            if (b < AW) bus.swdata = addr[b];
            else        bus.swdata = data[b-AW];
            bus.smode = (b == 0) ? mode : 1'($urandom);
            step();
        end
        exp_strobe = s + nbits + nstall;
        exp_done   = mode ? exp_strobe + 1 : exp_strobe + lat + 1 + DW;
        rdy_before = 1'bx; rdy_done = 1'bx;
        while (cyc < exp_done + 2) begin
            bus.mvalid = (toggle && cyc < exp_done) ? 1'($urandom) : 1'b0;
            bus.swdata = 1'($urandom); bus.smode = 1'($urandom);
            step();
            if (cyc == exp_done - 1) rdy_before = bus.sready;
            if (cyc == exp_done)     rdy_done   = bus.sready;
        end
        junk_en = 1'b0;
        if (mode) begin
            check({name, " wen_count"}, 32'(wen_cnt), 32'd1);
            check({name, " wen_cycle"}, 32'(wen_cyc), 32'(exp_strobe));
            check({name, " wen_addr"},  32'(wen_addr), 32'(addr));
            check({name, " wen_data"},  32'(wen_data), 32'(exp));
            check({name, " no_ren"},    32'(ren_cnt + sv_cnt), 32'd0);
            model_mem[addr] = data;
        end else begin
            check({name, " ren_count"}, 32'(ren_cnt), 32'd1);
            check({name, " ren_cycle"}, 32'(ren_cyc), 32'(exp_strobe));
            check({name, " ren_addr"},  32'(ren_addr), 32'(addr));
            check({name, " no_wen"},    32'(wen_cnt), 32'd0);
            check({name, " svalid_len"}, 32'(sv_cnt), 32'(DW));
            check({name, " svalid_first"}, 32'(sv_first), 32'(exp_strobe + lat + 1));
            check({name, " srdata_word"}, 32'(sv_word), 32'(exp));
        end
        check({name, " sready_busy"}, 32'(rdy_before), 32'd0);
        check({name, " sready_done"}, 32'(rdy_done), 32'd1);
        check({name, " sready_hold"}, 32'(bus.sready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ph_mem[i]    = 8'((i * 7 + 3) & 255);
            model_mem[i] = 8'((i * 7 + 3) & 255);
        end
        //            mode addr     data   pre stall len lat junk tog exp
        tbl[0] = '{1'b1, 12'h5A3, 8'hC6, 1'b0, -1, 0, 1, 1'b0, 1'b0, 8'hC6};
        tbl[1] = '{1'b0, 12'h0FF, 8'h3D, 1'b1, -1, 0, 2, 1'b0, 1'b0, 8'h3D};
        tbl[2] = '{1'b1, 12'h5A3, 8'hC6, 1'b0,  6, 3, 1, 1'b0, 1'b0, 8'hC6};
        tbl[3] = '{1'b0, 12'h0FF, 8'h3D, 1'b1, -1, 0, 2, 1'b1, 1'b1, 8'h3D};
        tbl[4] = '{1'b1, 12'h800, 8'hA5, 1'b0, -1, 0, 1, 1'b0, 1'b0, 8'hA5};
        tbl[5] = '{1'b0, 12'h800, 8'h00, 1'b0, -1, 0, 3, 1'b0, 1'b1, 8'hA5};
        tbl[6] = '{1'b1, 12'h123, 8'h5E, 1'b0, 15, 2, 1, 1'b0, 1'b0, 8'h5E};
        tbl[7] = '{1'b0, 12'h123, 8'h00, 1'b0,  4, 1, 1, 1'b0, 1'b0, 8'h5E};
        tbl[8] = '{1'b0, 12'hFFF, 8'h81, 1'b1, -1, 0, 6, 1'b1, 1'b0, 8'h81};

        rst = 1'b1; bus.mvalid = 1'b0; bus.swdata = 1'b0; bus.smode = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; cur_lat = 1;
        clear_log();
        step(); step();
        check("rst sready",    32'(bus.sready), 32'd0);
        check("rst svalid",    32'(bus.svalid), 32'd0);
        check("rst srdata",    32'(bus.srdata), 32'd0);
        check("rst strobes",   32'({mem_wen, mem_ren}), 32'd0);
        check("rst mem_addr",  32'(mem_addr), 32'd0);
        check("rst mem_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b0;
        step();
        check("rst sready_first", 32'(bus.sready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].pre) begin
                ph_mem[tbl[i].addr] = tbl[i].data;
                model_mem[tbl[i].addr] = tbl[i].data;
            end
            run_frame(tbl[i].mode, tbl[i].addr, tbl[i].data, tbl[i].stall_at, tbl[i].stall_len,
                      tbl[i].lat, tbl[i].junk, tbl[i].toggle, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Reset after six address bits must abandon the frame without side effects.
        clear_log();
        for (int b = 0; b < 6; b++) begin
            bus.mvalid = 1'b1; bus.smode = (b == 0); bus.swdata = 1'($urandom);
            step();
        end
        rst = 1'b1; bus.mvalid = 1'b1; bus.swdata = 1'b1;
        step();
        check("midrst sready",   32'(bus.sready), 32'd0);
        check("midrst mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0; bus.mvalid = 1'b0;
        step();
        check("midrst sready_release", 32'(bus.sready), 32'd1);
        repeat (20) step();
        check("midrst no_activity", 32'(wen_cnt + ren_cnt + sv_cnt), 32'd0);
        ph_mem[1] = 8'h96; model_mem[1] = 8'h96;
        run_frame(1'b0, 12'h001, 8'h00, -1, 0, 2, 1'b0, 1'b0, 8'h96, "midrst read001");

        for (int i = 0; i < 40; i++) begin
            bit            m;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            int            sa, nb;
            m = 1'($urandom_range(0, 1));
            if (written.size() > 0 && $urandom_range(0, 1) == 1)
                a = written[$urandom_range(0, written.size() - 1)];
            else
                a = AW'($urandom);
            d = DW'($urandom);
            nb = m ? AW + DW : AW;
            sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, nb - 1)) : -1;
            run_frame(m, a, d, sa, int'($urandom_range(1, 4)), int'($urandom_range(1, 5)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      m ? d : model_mem[a], $sformatf("rnd%0d", i));
            if (m) written.push_back(a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
